// File: rtl/semafor_ctrl.sv
// Master intersection sequencer: cycles vehicle phases A/B through green, yellow
// and all-red, hands off to the pedestrian block and enters/leaves night mode.
module semafor_ctrl #(
    parameter int T_VERDE     = 10,
    parameter int T_GALBEN    = 3,
    parameter int T_ROSU      = 2,
    parameter int PED_TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       buton_P,
    input  logic       mod_noapte,
    input  logic       ready_P,
    output logic [2:0] stare_semafor,
    output logic       cerere_P,
    output logic       ped_timeout
);

    typedef enum logic [2:0] {
        ROSU_A   = 3'b000,
        VERDE_A  = 3'b001,
        GALBEN_A = 3'b010,
        ROSU_B   = 3'b110,
        VERDE_B  = 3'b011,
        GALBEN_B = 3'b101,
        PIETONI  = 3'b100,
        NOAPTE   = 3'b111
    } state_t;

    localparam logic [5:0] V_LAST = 6'(T_VERDE - 1);
    localparam logic [5:0] G_LAST = 6'(T_GALBEN - 1);
    localparam logic [5:0] R_LAST = 6'(T_ROSU - 1);
    localparam logic [5:0] P_LAST = 6'(PED_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [5:0] cnt;
    logic       timeout_hit;
    logic       v_done, g_done, r_done, p_done;

    assign v_done = tick_1s && (cnt == V_LAST);
    assign g_done = tick_1s && (cnt == G_LAST);
    assign r_done = tick_1s && (cnt == R_LAST);
    assign p_done = tick_1s && (cnt == P_LAST);

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            ROSU_A: begin
                if (mod_noapte)  state_nxt = NOAPTE;
                else if (r_done) state_nxt = VERDE_A;
            end
            VERDE_A:  if (mod_noapte || v_done) state_nxt = GALBEN_A;
            GALBEN_A: if (g_done) state_nxt = mod_noapte ? NOAPTE : ROSU_B;
            ROSU_B: begin
                if (mod_noapte)  state_nxt = NOAPTE;
                else if (r_done) state_nxt = VERDE_B;
            end
            VERDE_B:  if (mod_noapte || v_done) state_nxt = GALBEN_B;
            // registered cerere_P: a press on the decision clk waits for the next cycle
            GALBEN_B: if (g_done) state_nxt = mod_noapte ? NOAPTE : (cerere_P ? PIETONI : ROSU_A);
            PIETONI: begin
                if (ready_P) begin
                    state_nxt = mod_noapte ? NOAPTE : ROSU_A;
                end else if (p_done) begin
                    state_nxt   = mod_noapte ? NOAPTE : ROSU_A;
                    timeout_hit = 1'b1;
                end
            end
            NOAPTE:   if (!mod_noapte) state_nxt = ROSU_A;
            default:  state_nxt = ROSU_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ROSU_A;
            cnt         <= '0;
            cerere_P    <= 1'b0;
            ped_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            ped_timeout <= timeout_hit;
            if (state_nxt != state || state == NOAPTE) cnt <= '0;
            else if (tick_1s)                          cnt <= cnt + 6'd1;
            if ((state_nxt == PIETONI && state != PIETONI) || state_nxt == NOAPTE)
                cerere_P <= 1'b0;
            else if (buton_P && state != PIETONI && state != NOAPTE)
                cerere_P <= 1'b1;
        end
    end

    assign stare_semafor = state;

endmodule
